// File: rtl/io_port_pkg.sv
// io_port_pkg: shared constants, FSM encoding and hex glyph table for the board I/O port.
package io_port_pkg;
    localparam int DATA_W = 16;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} stateT;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] hexSeg(input logic [3:0] h);
        return HEX_SEG[h];
    endfunction
endpackage

// File: rtl/fpga_io_port_if.sv
// fpga_io_port_if: board-side pins and processor FPGAIn/FPGAOut signals of the I/O port.
interface fpga_io_port_if #(parameter int DATA_W = io_port_pkg::DATA_W);
    logic [DATA_W-1:0] sw_in;
    logic              btn_load;
    logic [DATA_W-1:0] cpu_in;
    logic              in_valid;
    logic              in_ack;
    logic [DATA_W-1:0] cpu_out;
    logic              cpu_out_we;
    logic [DATA_W-1:0] out_reg;
    logic [3:0]        seg_an;
    logic [6:0]        seg_cat;

    modport master (
        output sw_in, btn_load, in_ack, cpu_out, cpu_out_we,
        input  cpu_in, in_valid, out_reg, seg_an, seg_cat
    );
    modport slave (
        input  sw_in, btn_load, in_ack, cpu_out, cpu_out_we,
        output cpu_in, in_valid, out_reg, seg_an, seg_cat
    );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: 2-flop synchronizers for switches and button, button debounce and press pulse.
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DATA_W          = io_port_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [DATA_W-1:0] swRaw,
    input  logic              btnRaw,
    output logic [DATA_W-1:0] swSync,
    output logic              load
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DATA_W-1:0] swMeta;
    logic              btnMeta, btnSync, btnStable, differ, settled;
    logic [CW-1:0]     cnt;

    assign differ  = btnSync != btnStable;
    assign settled = differ && cnt == CW'(DEBOUNCE_CYCLES - 1);

    // load is registered alongside the stable flip, so it pulses only on a press
    always_ff @(posedge CLK) begin
        if (!reset) begin
            swMeta    <= '0;
            swSync    <= '0;
            btnMeta   <= 1'b0;
            btnSync   <= 1'b0;
            btnStable <= 1'b0;
            cnt       <= '0;
            load      <= 1'b0;
        end else begin
            swMeta    <= swRaw;
            swSync    <= swMeta;
            btnMeta   <= btnRaw;
            btnSync   <= btnMeta;
            cnt       <= (differ && !settled) ? cnt + 1'b1 : '0;
            btnStable <= settled ? btnSync : btnStable;
            load      <= settled && btnSync;
        end
    end
endmodule

// File: rtl/fpga_io_port.sv
// fpga_io_port: committed input word with valid/ack handshake, output latch and 4-digit hex scan.
module fpga_io_port import io_port_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 4,
    parameter int DATA_W          = io_port_pkg::DATA_W
) (
    input logic           CLK,
    input logic           reset,
    fpga_io_port_if.slave io
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    logic [DATA_W-1:0] swSync, cpuIn, cpuInNext, outReg;
    logic              load, wrap;
    stateT             state, stateNext;
    logic [PW-1:0]     presc;
    logic [1:0]        digit, digitNext;
    logic [3:0]        segAn;
    logic [6:0]        segCat;

    sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DATA_W(DATA_W)) uSync (
        .CLK(CLK),
        .reset(reset),
        .swRaw(io.sw_in),
        .btnRaw(io.btn_load),
        .swSync(swSync),
        .load(load)
    );

    // A load always wins over an ack, so a colliding press keeps the word valid
    always_comb begin
        stateNext = load ? HOLD : (io.in_ack ? IDLE : state);
        cpuInNext = load ? swSync : cpuIn;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state  <= IDLE;
            cpuIn  <= '0;
            outReg <= '0;
        end else begin
            state  <= stateNext;
            cpuIn  <= cpuInNext;
            outReg <= io.cpu_out_we ? io.cpu_out : outReg;
        end
    end

    assign wrap      = presc == PW'(SCAN_DIV - 1);
    assign digitNext = digit + 2'd1;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            presc  <= '0;
            digit  <= 2'd0;
            segAn  <= 4'b1110;
            segCat <= hexSeg(4'h0);
        end else if (wrap) begin
            presc  <= '0;
            digit  <= digitNext;
            segAn  <= ~(4'b0001 << digitNext);
            segCat <= hexSeg(outReg[{digitNext, 2'b00} +: 4]);
        end else begin
            presc  <= presc + 1'b1;
        end
    end

    assign io.cpu_in   = cpuIn;
    assign io.in_valid = state == HOLD;
    assign io.out_reg  = outReg;
    assign io.seg_an   = segAn;
    assign io.seg_cat  = segCat;
endmodule

// File: tb/tb_fpga_io_port.sv
// tb_fpga_io_port: scoreboard bench for handshake timing, debounce, output latch and display scan.
module tb_fpga_io_port;
    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    fpga_io_port_if bus ();
    fpga_io_port dut (.CLK(CLK), .reset(reset), .io(bus));

    int total = 0;
    int bad = 0;
    logic [31:0] sb[$];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic popChk(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = 32'hdeadbeef;
        if (sb.size() > 0) e = sb.pop_front();
        checkEq(tag, got, e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [3:0] ans[4];
        logic [6:0] cats[4];
        logic [3:0] prev;
        logic seen, found;
        ans  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        cats = '{7'b1111000, 7'b0110000, 7'b1000000, 7'b1000000};
        bus.sw_in = '0;
        bus.btn_load = 1'b0;
        bus.in_ack = 1'b0;
        bus.cpu_out = '0;
        bus.cpu_out_we = 1'b0;

        // reset state and ack while idle
        step(2);
        checkEq("rst cpu_in", 32'(bus.cpu_in), 0);
        checkEq("rst in_valid", 32'(bus.in_valid), 0);
        checkEq("rst out_reg", 32'(bus.out_reg), 0);
        checkEq("rst seg_an", 32'(bus.seg_an), 32'b1110);
        checkEq("rst seg_cat", 32'(bus.seg_cat), 32'b1000000);
        reset = 1'b1;
        bus.in_ack = 1'b1;
        step();
        bus.in_ack = 1'b0;
        step();
        checkEq("idle ack valid", 32'(bus.in_valid), 0);
        checkEq("idle ack data", 32'(bus.cpu_in), 0);

        // clean press: valid exactly 19 cycles after the raw edge
        bus.sw_in = 16'd10;
        bus.btn_load = 1'b1;
        sb.push_back(32'h000A);
        step(18);
        checkEq("lat18 valid", 32'(bus.in_valid), 0);
        step();
        checkEq("lat19 valid", 32'(bus.in_valid), 1);
        popChk("load data", 32'(bus.cpu_in));
        step(6);
        checkEq("held valid", 32'(bus.in_valid), 1);
        bus.btn_load = 1'b0;
        step(24);
        checkEq("release valid", 32'(bus.in_valid), 1);
        bus.in_ack = 1'b1;
        step();
        bus.in_ack = 1'b0;
        checkEq("ack valid", 32'(bus.in_valid), 0);
        checkEq("ack keep data", 32'(bus.cpu_in), 32'h000A);

        // bouncing button never commits
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.btn_load = ((i / 5) % 2) == 0;
            step();
            if (bus.in_valid) seen = 1'b1;
        end
        bus.btn_load = 1'b0;
        step(24);
        if (bus.in_valid) seen = 1'b1;
        checkEq("bounce seen", 32'(seen), 0);

        // collision of load and ack
        bus.sw_in = 16'h000A;
        bus.btn_load = 1'b1;
        sb.push_back(32'h000A);
        step(19);
        popChk("hold data", 32'(bus.cpu_in));
        bus.btn_load = 1'b0;
        step(24);
        bus.sw_in = 16'h0003;
        bus.btn_load = 1'b1;
        sb.push_back(32'h0003);
        step(18);
        bus.in_ack = 1'b1;
        step();
        bus.in_ack = 1'b0;
        checkEq("coll valid", 32'(bus.in_valid), 1);
        popChk("coll data", 32'(bus.cpu_in));
        step();
        checkEq("coll valid after", 32'(bus.in_valid), 1);

        // second press while holding: latest word wins
        bus.btn_load = 1'b0;
        step(24);
        bus.sw_in = 16'h0005;
        bus.btn_load = 1'b1;
        sb.push_back(32'h0005);
        step(19);
        popChk("latest data", 32'(bus.cpu_in));
        checkEq("latest valid", 32'(bus.in_valid), 1);
        bus.btn_load = 1'b0;
        step(24);

        // back-to-back writes then display scan of 0x0037
        bus.cpu_out_we = 1'b1;
        bus.cpu_out = 16'h1234;
        sb.push_back(32'h1234);
        step();
        popChk("out first", 32'(bus.out_reg));
        bus.cpu_out = 16'h0037;
        sb.push_back(32'h0037);
        step();
        bus.cpu_out_we = 1'b0;
        popChk("out last", 32'(bus.out_reg));
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = bus.seg_an;
            step();
            found = prev == 4'b0111 && bus.seg_an == 4'b1110;
        end
        checkEq("scan sync", 32'(found), 1);
        for (int i = 0; i < 16; i++) sb.push_back(32'({ans[i/4], cats[i/4]}));
        for (int i = 0; i < 16; i++) begin
            popChk("scan", 32'({bus.seg_an, bus.seg_cat}));
            step();
        end

        // reset mid-hold with the button still held
        bus.sw_in = 16'h000A;
        bus.btn_load = 1'b1;
        sb.push_back(32'h000A);
        step(19);
        popChk("pre-reset data", 32'(bus.cpu_in));
        reset = 1'b0;
        step();
        reset = 1'b1;
        checkEq("mid rst valid", 32'(bus.in_valid), 0);
        checkEq("mid rst cpu_in", 32'(bus.cpu_in), 0);
        checkEq("mid rst out_reg", 32'(bus.out_reg), 0);
        checkEq("mid rst seg_an", 32'(bus.seg_an), 32'b1110);
        checkEq("mid rst seg_cat", 32'(bus.seg_cat), 32'b1000000);
        sb.push_back(32'h000A);
        step(3);
        checkEq("scan restart d0", 32'(bus.seg_an), 32'b1110);
        step();
        checkEq("scan restart d1", 32'(bus.seg_an), 32'b1101);
        step(14);
        checkEq("post rst lat18", 32'(bus.in_valid), 0);
        step();
        checkEq("post rst lat19", 32'(bus.in_valid), 1);
        popChk("post rst data", 32'(bus.cpu_in));
        checkEq("sb drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
